// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes and FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SHL   = 3'd2,
        OP_SHR   = 3'd3,
        OP_ROL   = 3'd4,
        OP_ROR   = 3'd5,
        OP_ASR   = 3'd6,
        OP_CLEAR = 3'd7
    } op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic logic is_shift(op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit step of a shift/rotate operation; non-shift ops pass q through.
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            OP_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle load/clear/hold, multi-cycle shifts of up to WIDTH steps.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             sout_l,
    output logic             sout_r
);

    localparam logic [CNT_W-1:0] MaxAmt = CNT_W'(WIDTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    op_e              op_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_step;
    logic             done_q;
    op_e              op_in;
    logic [CNT_W-1:0] amt_eff;

    assign op_in   = op_e'(op);
    assign amt_eff = (amt > MaxAmt) ? MaxAmt : amt;

    // Step logic always works on the latched op so mid-run changes on op are invisible.
    usr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q      (q_q),
        .op     (op_q),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_shift(op_in)) begin
                            if (amt_eff == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                cnt_q   <= amt_eff;
                                op_q    <= op_in;
                            end
                        end else begin
                            if (op_in == OP_LOAD) begin
                                q_q <= d;
                            end else if (op_in == OP_CLEAR) begin
                                q_q <= '0;
                            end
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    q_q   <= q_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign q      = q_q;
    assign busy   = (state_q == StRun);
    assign done   = done_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

endmodule
